piradspi_subordinate: RTL and testbench

SPI responder (subordinate) endpoint: the far end of the PiRadSPI manager engine, used as an on-chip loopback target and for FPGA-as-peripheral designs. Oversamples SCLK/CSN/MOSI in the aclk domain, deserialises MOSI into AXI-stream words, and serialises MISO from an AXI-stream TX FIFO. Mode (CPOL/CPHA) is latched at each CSN assertion; overrun, underrun and partial-word errors are reported through sticky flags.

---
 rtl/piradspi_subordinate.sv | 209 ++++++++++++++++++++
 tb/tb_piradspi_subordinate.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/piradspi_subordinate.sv
`default_nettype none
// ============================================================================
// piradspi_subordinate: SPI responder endpoint, oversampled in the aclk domain,
// AXI-stream RX/TX with sticky overrun/underrun/partial-word flags.
// Revision: 1.0
// ============================================================================
module piradspi_subordinate #(
   parameter int          DATA_WIDTH  = 32,
   parameter int          SYNC_STAGES = 2,
   parameter logic [31:0] FILL_WORD   = 32'hFFFF_FFFF
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  cpol,
   input  logic                  cpha,
   input  logic                  spi_sclk,
   input  logic                  spi_csn,
   input  logic                  spi_mosi,
   output logic                  spi_miso,
   output logic                  spi_miso_oe,
   input  logic [DATA_WIDTH-1:0] axis_tx_tdata,
   input  logic                  axis_tx_tvalid,
   output logic                  axis_tx_tready,
   output logic [DATA_WIDTH-1:0] axis_rx_tdata,
   output logic                  axis_rx_tvalid,
   input  logic                  axis_rx_tready,
   output logic                  frame_end,
   output logic                  busy,
   output logic                  err_overrun,
   output logic                  err_underrun,
   output logic                  err_partial,
   input  logic                  clr_status
);

   localparam int                     CW       = $clog2(DATA_WIDTH + 1);
   localparam logic [CW-1:0]          LAST_BIT = CW'(DATA_WIDTH - 1);
   localparam logic [DATA_WIDTH-1:0]  FILL     = FILL_WORD[DATA_WIDTH-1:0];

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [2:0]            sync_q [SYNC_STAGES];
   logic                  sclk_prev_q, csn_prev_q;
   logic                  cpol_q, cpol_d, cpha_q, cpha_d;
   logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-2:0] rx_shift_q, rx_shift_d;
   logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic                  rx_valid_q, rx_valid_d;
   logic                  skip_q, skip_d;
   logic                  frame_end_q, frame_end_d;
   logic                  err_ovr_q, err_ovr_d, err_und_q, err_und_d, err_par_q, err_par_d;

   logic                  sclk_s, csn_s, mosi_s;
   logic                  lead_edge, trail_edge, sample_edge, shift_edge;
   logic                  csn_fall, csn_rise;
   logic                  tx_load, word_done, set_ovr, set_und, set_par;
   logic [DATA_WIDTH-1:0] new_word;

   assign {mosi_s, csn_s, sclk_s} = sync_q[SYNC_STAGES-1];

   // Edge polarity is relative to the mode captured at CSN fall.
   assign lead_edge   = (sclk_s != sclk_prev_q) && (sclk_s != cpol_q);
   assign trail_edge  = (sclk_s != sclk_prev_q) && (sclk_s == cpol_q);
   assign sample_edge = cpha_q ? trail_edge : lead_edge;
   assign shift_edge  = cpha_q ? lead_edge  : trail_edge;
   assign csn_fall    = csn_prev_q & ~csn_s;
   assign csn_rise    = ~csn_prev_q & csn_s;
   assign new_word    = {rx_shift_q, mosi_s};

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 3'b010;
         sclk_prev_q <= 1'b0;
         csn_prev_q  <= 1'b1;
         state_q     <= IDLE;
         cpol_q      <= 1'b0;
         cpha_q      <= 1'b0;
         bit_cnt_q   <= '0;
         rx_shift_q  <= '0;
         tx_shift_q  <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         skip_q      <= 1'b0;
         frame_end_q <= 1'b0;
         err_ovr_q   <= 1'b0;
         err_und_q   <= 1'b0;
         err_par_q   <= 1'b0;
      end else begin
         sync_q[0] <= {spi_mosi, spi_csn, spi_sclk};
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         sclk_prev_q <= sclk_s;
         csn_prev_q  <= csn_s;
         state_q     <= state_d;
         cpol_q      <= cpol_d;
         cpha_q      <= cpha_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_shift_q  <= rx_shift_d;
         tx_shift_q  <= tx_shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         skip_q      <= skip_d;
         frame_end_q <= frame_end_d;
         err_ovr_q   <= err_ovr_d;
         err_und_q   <= err_und_d;
         err_par_q   <= err_par_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cpol_d      = cpol_q;
      cpha_d      = cpha_q;
      bit_cnt_d   = bit_cnt_q;
      rx_shift_d  = rx_shift_q;
      tx_shift_d  = tx_shift_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q;
      skip_d      = skip_q;
      frame_end_d = 1'b0;
      tx_load     = 1'b0;
      word_done   = 1'b0;
      set_ovr     = 1'b0;
      set_und     = 1'b0;
      set_par     = 1'b0;

      if (rx_valid_q && axis_rx_tready) rx_valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (csn_fall) begin
               cpol_d    = cpol;
               cpha_d    = cpha;
               bit_cnt_d = '0;
               tx_load   = 1'b1;
               // CPHA=1: the first leading edge re-presents the MSB already on MISO.
               skip_d    = cpha;
               state_d   = ACTIVE;
            end
         end
         ACTIVE: begin
            if (csn_rise) begin
               state_d     = IDLE;
               frame_end_d = 1'b1;
               tx_shift_d  = '0;
               skip_d      = 1'b0;
               bit_cnt_d   = '0;
               set_par     = (bit_cnt_q != '0);
            end else begin
               if (sample_edge) begin
                  rx_shift_d = new_word[DATA_WIDTH-2:0];
                  if (bit_cnt_q == LAST_BIT) begin
                     bit_cnt_d = '0;
                     word_done = 1'b1;
                     tx_load   = 1'b1;
                     // The new MSB is already on MISO; the next shift edge must hold it.
                     skip_d    = 1'b1;
                  end else begin
                     bit_cnt_d = bit_cnt_q + CW'(1);
                  end
               end
               if (shift_edge) begin
                  if (skip_q) skip_d = 1'b0;
                  else        tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (word_done) begin
         if (!rx_valid_q || axis_rx_tready) begin
            rx_data_d  = new_word;
            rx_valid_d = 1'b1;
         end else begin
            set_ovr = 1'b1;
         end
      end

      if (tx_load) begin
         if (axis_tx_tvalid) begin
            tx_shift_d = axis_tx_tdata;
         end else begin
            tx_shift_d = FILL;
            set_und    = 1'b1;
         end
      end

      err_ovr_d = set_ovr | (err_ovr_q & ~clr_status);
      err_und_d = set_und | (err_und_q & ~clr_status);
      err_par_d = set_par | (err_par_q & ~clr_status);
   end

   assign axis_tx_tready = tx_load & axis_tx_tvalid;
   assign spi_miso       = tx_shift_q[DATA_WIDTH-1];
   assign spi_miso_oe    = (state_q == ACTIVE);
   assign busy           = (state_q == ACTIVE);
   assign axis_rx_tdata  = rx_data_q;
   assign axis_rx_tvalid = rx_valid_q;
   assign frame_end      = frame_end_q;
   assign err_overrun    = err_ovr_q;
   assign err_underrun   = err_und_q;
   assign err_partial    = err_par_q;

endmodule
`default_nettype wire

// File: tb/tb_piradspi_subordinate.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_piradspi_subordinate: SPI manager model driving the responder, with an
// AXI-stream TX source and a scoreboard on the RX stream.
// Revision: 1.0
// ============================================================================
module tb_piradspi_subordinate;

   localparam int H = 80;  // SCLK half period in ns (aclk period 10 ns)

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        cpol = 1'b0, cpha = 1'b0;
   logic        spi_sclk = 1'b0, spi_csn = 1'b1, spi_mosi = 1'b0;
   logic        spi_miso, spi_miso_oe;
   logic [31:0] axis_tx_tdata = '0;
   logic        axis_tx_tvalid = 1'b0;
   logic        axis_tx_tready;
   logic [31:0] axis_rx_tdata;
   logic        axis_rx_tvalid;
   logic        axis_rx_tready = 1'b1;
   logic        frame_end, busy, err_overrun, err_underrun, err_partial;
   logic        clr_status = 1'b0;

   int          n_checks = 0;
   int          n_pass = 0;
   int          frame_cnt = 0;
   int          f0;
   logic [31:0] exp_rx_q[$];
   logic [31:0] txq[$];
   logic        tx_pend = 1'b0;
   logic [31:0] mi0, mi1;

   piradspi_subordinate #(
      .DATA_WIDTH (32),
      .SYNC_STAGES(2),
      .FILL_WORD  (32'hFFFF_FFFF)
   ) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .cpol          (cpol),
      .cpha          (cpha),
      .spi_sclk      (spi_sclk),
      .spi_csn       (spi_csn),
      .spi_mosi      (spi_mosi),
      .spi_miso      (spi_miso),
      .spi_miso_oe   (spi_miso_oe),
      .axis_tx_tdata (axis_tx_tdata),
      .axis_tx_tvalid(axis_tx_tvalid),
      .axis_tx_tready(axis_tx_tready),
      .axis_rx_tdata (axis_rx_tdata),
      .axis_rx_tvalid(axis_rx_tvalid),
      .axis_rx_tready(axis_rx_tready),
      .frame_end     (frame_end),
      .busy          (busy),
      .err_overrun   (err_overrun),
      .err_underrun  (err_underrun),
      .err_partial   (err_partial),
      .clr_status    (clr_status)
   );

   always #5 aclk = ~aclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // RX scoreboard: a handshake seen mid-cycle completes at the next rising edge.
   always @(negedge aclk) begin
      if (aresetn && axis_rx_tvalid && axis_rx_tready) begin
         if (exp_rx_q.size() == 0) begin
            n_checks++;
            $display("FAIL rx_unexpected: got %h, expected no word", axis_rx_tdata);
         end else begin
            check("rx_word", axis_rx_tdata, exp_rx_q.pop_front());
         end
      end
      if (frame_end) frame_cnt++;
      tx_pend = axis_tx_tvalid && axis_tx_tready;
   end

   // TX source: presents the head of txq, pops after an accepted handshake.
   always @(posedge aclk) begin
      #1;
      if (tx_pend && txq.size() > 0) void'(txq.pop_front());
      axis_tx_tvalid = (txq.size() > 0);
      axis_tx_tdata  = (txq.size() > 0) ? txq[0] : 32'h0;
   end

   task automatic idle(input int n);
      repeat (n) @(posedge aclk);
      #1;
   endtask

   task automatic set_mode(input logic [1:0] m);
      cpol     = m[1];
      cpha     = m[0];
      spi_sclk = m[1];
   endtask

   task automatic csn_low();
      spi_csn = 1'b0;
      #(H);
   endtask

   task automatic csn_high();
      #(H);
      spi_csn = 1'b1;
      #(4*H);
   endtask

   task automatic xfer(input logic [31:0] mo, input int nbits, output logic [31:0] mi);
      mi = '0;
      for (int i = 0; i < nbits; i++) begin
         if (!cpha) begin
            spi_mosi = mo[31-i];
            #(H);
            mi = {mi[30:0], spi_miso};
            spi_sclk = ~cpol;
            #(H);
            spi_sclk = cpol;
         end else begin
            spi_sclk = ~cpol;
            spi_mosi = mo[31-i];
            #(H);
            mi = {mi[30:0], spi_miso};
            spi_sclk = cpol;
            #(H);
         end
      end
   endtask

   task automatic clear_status();
      clr_status = 1'b1;
      idle(1);
      clr_status = 1'b0;
   endtask

   initial begin
      logic [1:0] md;
      idle(3);
      check("rst_miso",      spi_miso, 0);
      check("rst_oe",        spi_miso_oe, 0);
      check("rst_tx_tready", axis_tx_tready, 0);
      check("rst_rx_tvalid", axis_rx_tvalid, 0);
      check("rst_rx_tdata",  axis_rx_tdata, 0);
      check("rst_frame_end", frame_end, 0);
      check("rst_busy",      busy, 0);
      check("rst_errs",      {err_overrun, err_underrun, err_partial}, 0);
      aresetn = 1'b1;
      idle(4);

      // Mode 0 single word; the extra TX word is the discarded prefetch.
      f0 = frame_cnt;
      txq.push_back(32'hA5A5_0F0F);
      txq.push_back(32'h0000_0000);
      exp_rx_q.push_back(32'h1234_5678);
      idle(3);
      csn_low();
      check("m0_busy", busy, 1);
      xfer(32'h1234_5678, 32, mi0);
      csn_high();
      check("m0_miso", mi0, 32'hA5A5_0F0F);
      check("m0_frame_end_count", frame_cnt - f0, 1);
      check("m0_errs", {err_overrun, err_underrun, err_partial}, 0);
      check("m0_idle_oe", spi_miso_oe, 0);

      for (int m = 1; m < 4; m++) begin
         md = m[1:0];
         set_mode(md);
         idle(4);
         txq.push_back(32'hDEAD_BEEF);
         txq.push_back(32'h0000_0001);
         txq.push_back(32'h0000_0000);
         exp_rx_q.push_back(32'hCAFE_F00D);
         exp_rx_q.push_back(32'h8000_0000);
         idle(3);
         csn_low();
         xfer(32'hCAFE_F00D, 32, mi0);
         xfer(32'h8000_0000, 32, mi1);
         csn_high();
         check($sformatf("mode%0d_miso0", m), mi0, 32'hDEAD_BEEF);
         check($sformatf("mode%0d_miso1", m), mi1, 32'h0000_0001);
         check($sformatf("mode%0d_errs", m), {err_overrun, err_underrun, err_partial}, 0);
      end

      // Underrun: nothing queued at CSN fall.
      set_mode(2'd0);
      idle(4);
      exp_rx_q.push_back(32'h0000_0000);
      csn_low();
      xfer(32'h0000_0000, 32, mi0);
      csn_high();
      check("underrun_miso", mi0, 32'hFFFF_FFFF);
      check("underrun_flag", err_underrun, 1);
      clear_status();
      check("underrun_cleared", err_underrun, 0);

      // Overrun: consumer stalled over three words.
      axis_rx_tready = 1'b0;
      for (int k = 0; k < 4; k++) txq.push_back(32'h0F0F_0F0F);
      exp_rx_q.push_back(32'h1111_1111);
      idle(3);
      csn_low();
      xfer(32'h1111_1111, 32, mi0);
      xfer(32'h2222_2222, 32, mi0);
      xfer(32'h3333_3333, 32, mi0);
      csn_high();
      check("overrun_flag", err_overrun, 1);
      check("overrun_held_valid", axis_rx_tvalid, 1);
      check("overrun_held_data", axis_rx_tdata, 32'h1111_1111);
      axis_rx_tready = 1'b1;
      idle(8);
      check("overrun_drained", exp_rx_q.size(), 0);
      check("overrun_no_more", axis_rx_tvalid, 0);
      clear_status();

      // Partial word, then a clean frame.
      txq.push_back(32'h0000_0000);
      idle(3);
      csn_low();
      xfer(32'hABCD_EF01, 12, mi0);
      csn_high();
      check("partial_flag", err_partial, 1);
      check("partial_no_rx", axis_rx_tvalid, 0);
      check("partial_no_underrun", err_underrun, 0);
      clear_status();
      check("partial_cleared", err_partial, 0);
      txq.push_back(32'h6666_9999);
      txq.push_back(32'h0000_0000);
      exp_rx_q.push_back(32'h0000_00FF);
      idle(3);
      csn_low();
      xfer(32'h0000_00FF, 32, mi0);
      csn_high();
      check("after_partial_miso", mi0, 32'h6666_9999);
      check("after_partial_errs", {err_overrun, err_underrun, err_partial}, 0);

      // Reset asserted mid-word.
      txq.push_back(32'h1234_0000);
      idle(3);
      csn_low();
      xfer(32'hFFFF_FFFF, 17, mi0);
      aresetn = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_oe", spi_miso_oe, 0);
      check("midrst_miso", spi_miso, 0);
      check("midrst_rx_tvalid", axis_rx_tvalid, 0);
      spi_csn  = 1'b1;
      spi_sclk = cpol;
      idle(4);
      aresetn = 1'b1;
      idle(4);
      txq.delete();
      txq.push_back(32'h0F0F_F0F0);
      txq.push_back(32'h0000_0000);
      exp_rx_q.push_back(32'h5555_AAAA);
      idle(3);
      csn_low();
      xfer(32'h5555_AAAA, 32, mi0);
      csn_high();
      check("after_rst_miso", mi0, 32'h0F0F_F0F0);
      check("after_rst_errs", {err_overrun, err_underrun, err_partial}, 0);

      idle(20);
      check("rx_all_delivered", exp_rx_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
